cspc_cslow_accum_blk: RTL
=========================

// Module: cspc_cslow_accum_blk
// PURPOSE
//  C-slowed multi-thread accumulator; block side of the CSPC blk_* interface.
//  - One item per enabled clock, slots in round-robin order 0..NUM_PORTS-1.
//  - Keeps NUM_PORTS independent accumulator threads in a register ring.
//  - Returns each slot's result exactly NUM_PORTS enabled cycles after its input, which is the latency the RR scheduler assumes.
// PARAMETERS
//  NUM_PORTS   4   number of threads (C); ring depth; >=2
//  WIDTH_IN    16  blk_in width, signed two's complement
//  WIDTH_ACC   16  accumulator/out width, signed; >= WIDTH_IN
// PORTS
//  clk        in   1          clock (the minor clock)
//  rst        in   1          asynchronous, active-high reset
//  clr        in   1          synchronous clear, driven from blk_rst
//  en         in   1          clock enable, driven from blk_en; all state holds when low
//  in         in   WIDTH_IN   operand for the current slot
//  common_in  in   2          opcode shared by all slots: [1:0] op
//  out        out  WIDTH_ACC  result for slot (current slot - NUM_PORTS)
//  ovf        out  1          sticky overflow flag of the thread shown on out
// BEHAVIOUR
//  - Clock and reset: single clock clk; reset rst is asynchronous and active-high.
//  - Ring: R[0..N-1] (acc+flag); on en: R[0]<=f(R[N-1],in,op), R[i]<=R[i-1]; out/ovf = R[N-1].
//  - Latency: input presented at enabled cycle k appears on out at enabled cycle k+N. Cycles with en=0 do not count.
//  - Slot identity is implicit (ring position). The block has no slot counter and never reorders.
//  - Ops, x=sign-extended in:
//    - 00 ADD: acc+x
//    - 01 SUB: acc-x
//    - 10 LOAD: x, clears ovf
//    - 11 HOLD: acc unchanged
//  - Arithmetic: computed at WIDTH_ACC+1 bits. Overflow = result outside the WIDTH_ACC signed range.
//  - ovf: ovf_new = ovf_old | overflow. Only LOAD clears it.
//  - rst asserted: all R cleared to 0/0 immediately, at any time including mid-stream; out=0, ovf=0.
//  - clr=1 and en=1 at an edge: all R cleared to 0 (sync).
//  - clr=1 and en=0: no effect. clr has priority over op.
//  - Simultaneous rst and clr: rst wins (async).
//  - Boundaries:
//    - Wrap-around of the ring is continuous.
//    - LOAD of the most-negative value is legal, no overflow.
//    - SUB of the most-negative x from 0 overflows.
// CONFIGURATION
//  - Macro CSPC_ACCUM_SAT_EN controls overflow handling; ovf flagging is identical in both builds.
//  - Defined: on overflow, the stored acc clamps to +max (2^(W-1)-1) or -min (-2^(W-1)).
//  - Undefined: on overflow, the stored acc wraps modulo 2^WIDTH_ACC.
// STRUCTURE
//  - Shared package cspc_pkg:
//    - CSPC_OP_ADD/SUB/LOAD/HOLD 2-bit constants
//    - CSPC_OP_WIDTH=2
//  - Sub-module cspc_accum_alu (combinational):
//    - op, extend, add/sub, overflow detect, sat/wrap select
//    - one instance feeds R[0]
//  - Top level holds the ring registers, the async reset and the clr/en logic.
// TESTING  (N=4, WIDTH_IN=16, WIDTH_ACC=16)
//  - Latency: en=1, ADD, in=1,2,3,4 on slots 0..3, then in=0.
//    -> out reads 1,2,3,4 exactly 4 cycles later, and again 4 cycles after that.
//  - Thread isolation: 3 rounds of ADD in=10*slot+1.
//    -> out is 3,33,63,93 on the 3rd round; ovf=0.
//  - Enable gating: insert 5 en=0 cycles mid-round with in toggling.
//    -> the out sequence is unchanged apart from the stall; no state advance.
//  - Overflow: LOAD 32767 on slot 2, then ADD 1.
//    -> wrap build: -32768, ovf=1. SAT build: 32767, ovf=1.
//    -> a later LOAD 5 clears ovf to 0.
//  - Reset mid-op: assert rst asynchronously between edges after 2 rounds.
//    -> out=0, ovf=0 immediately; next round of ADD 7 returns 7 on all slots.
//  - Clear vs enable: clr=1 with en=0 -> no change; clr=1 with en=1 for one edge.
//    -> all threads read 0 on the following round.

Source files
------------

// File: rtl/cspc_pkg.sv
// Shared CSPC definitions: opcode encodings and widths used by blocks
// that ride the blk_* interface.
package cspc_pkg;

    localparam int CSPC_OP_WIDTH = 2;

    localparam logic [CSPC_OP_WIDTH-1:0] CSPC_OP_ADD  = 2'b00;
    localparam logic [CSPC_OP_WIDTH-1:0] CSPC_OP_SUB  = 2'b01;
    localparam logic [CSPC_OP_WIDTH-1:0] CSPC_OP_LOAD = 2'b10;
    localparam logic [CSPC_OP_WIDTH-1:0] CSPC_OP_HOLD = 2'b11;

endpackage

// File: rtl/cspc_cslow_accum_blk_if.sv
// Block-side blk_* bundle for the C-slowed accumulator: control, operand,
// shared opcode and the per-slot result/flag.
interface cspc_cslow_accum_blk_if
    import cspc_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 16
);
    logic                     clr;
    logic                     en;
    logic [WIDTH_IN-1:0]      in;
    logic [CSPC_OP_WIDTH-1:0] common_in;
    logic [WIDTH_ACC-1:0]     out;
    logic                     ovf;

    modport master (output clr, en, in, common_in, input out, ovf);
    modport slave  (input clr, en, in, common_in, output out, ovf);
endinterface

// File: rtl/cspc_accum_alu.sv
// Combinational accumulator step: op decode, sign-extend, add/sub at W+1 bits,
// overflow detect, then saturate (CSPC_ACCUM_SAT_EN) or wrap.
module cspc_accum_alu
    import cspc_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 16
) (
    input  logic [CSPC_OP_WIDTH-1:0] op,
    input  logic [WIDTH_IN-1:0]      x,
    input  logic [WIDTH_ACC-1:0]     acc,
    input  logic                     ovf,
    output logic [WIDTH_ACC-1:0]     acc_nxt,
    output logic                     ovf_nxt
);
    localparam int WE = WIDTH_ACC + 1;

    logic [WE-1:0] x_ext;
    logic [WE-1:0] acc_ext;
    logic [WE-1:0] res;
    logic          over;

    assign x_ext   = {{(WE-WIDTH_IN){x[WIDTH_IN-1]}}, x};
    assign acc_ext = {acc[WIDTH_ACC-1], acc};

    always_comb begin
        res = acc_ext;
        case (op)
            CSPC_OP_ADD:  res = acc_ext + x_ext;
            CSPC_OP_SUB:  res = acc_ext - x_ext;
            CSPC_OP_LOAD: res = x_ext;
            default:      res = acc_ext;
        endcase
    end

    // Result leaves the signed range when the two top bits disagree.
    assign over = res[WE-1] ^ res[WE-2];

    always_comb begin
        acc_nxt = res[WIDTH_ACC-1:0];
`ifdef CSPC_ACCUM_SAT_EN
        if (over)
            acc_nxt = res[WE-1] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                : {1'b0, {(WIDTH_ACC-1){1'b1}}};
`endif
    end

    assign ovf_nxt = (op == CSPC_OP_LOAD) ? 1'b0 : (ovf | over);

endmodule

// File: rtl/cspc_cslow_accum_blk.sv
// C-slowed NUM_PORTS-thread accumulator: a register ring where each slot's
// state returns to the ALU exactly NUM_PORTS enabled cycles later.
// Build option: CSPC_ACCUM_SAT_EN selects saturating instead of wrapping overflow.
module cspc_cslow_accum_blk
    import cspc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 16
) (
    input logic                   clk,
    input logic                   rst,
    cspc_cslow_accum_blk_if.slave blk
);
    logic [NUM_PORTS-1:0][WIDTH_ACC-1:0] acc_q;
    logic [NUM_PORTS-1:0]                ovf_q;
    logic [WIDTH_ACC-1:0]                acc_nxt;
    logic                                ovf_nxt;

    cspc_accum_alu #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_ACC (WIDTH_ACC)
    ) u_alu (
        .op      (blk.common_in),
        .x       (blk.in),
        .acc     (acc_q[NUM_PORTS-1]),
        .ovf     (ovf_q[NUM_PORTS-1]),
        .acc_nxt (acc_nxt),
        .ovf_nxt (ovf_nxt)
    );

    // clr only acts on enabled edges; en low freezes the whole ring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= '0;
        end else if (blk.en) begin
            if (blk.clr) begin
                acc_q <= '0;
                ovf_q <= '0;
            end else begin
                acc_q[0] <= acc_nxt;
                ovf_q[0] <= ovf_nxt;
                for (int i = 1; i < NUM_PORTS; i++) begin
                    acc_q[i] <= acc_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                end
            end
        end
    end

    assign blk.out = acc_q[NUM_PORTS-1];
    assign blk.ovf = ovf_q[NUM_PORTS-1];

endmodule
